mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels; legal range 2..8.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; multiple of 8.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, SRAM access cycles per transaction; legal range 1..15.
REQ-005 SHALL have parameter RR_MODE, default 1; 0 = fixed priority, 1 = round-robin.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port req_valid  input  NUM_CH  per-channel request.
REQ-009 SHALL have port req_ready  output  NUM_CH  per-channel accept, one-hot or zero.
REQ-010 SHALL have port req_we  input  NUM_CH*DW/8  per-channel byte write enables; all-zero means read.
REQ-011 SHALL have port req_addr  input  NUM_CH*AW  per-channel address; channel i at bits [i*AW +: AW].
REQ-012 SHALL have port req_wdata  input  NUM_CH*DW  per-channel write data.
REQ-013 SHALL have port resp_valid  output  NUM_CH  one-cycle completion pulse to the owning channel.
REQ-014 SHALL have port resp_rdata  output  DW  shared read data, valid only with resp_valid.
REQ-015 SHALL have ports sram_en (1), sram_we (DW/8), sram_addr (AW), sram_wdata (DW) as outputs, and sram_rdata (DW) as input.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-018 IDLE: if any req_valid is high, SHALL assert req_ready for exactly one granted channel in the same cycle (combinational), latch that channel's we/addr/wdata and index, load wait counter with WAIT_CYCLES-1, and move to ACCESS.
REQ-019 Fixed priority (RR_MODE=0): the lowest-index valid channel SHALL win.
REQ-020 Round-robin (RR_MODE=1): search SHALL start at (last_grant+1) mod NUM_CH; last_grant SHALL update only on a grant.
REQ-021 req_ready SHALL be all-zero in ACCESS and DONE, and in IDLE when no req_valid is high.
REQ-022 ACCESS: sram_en=1, with sram_we/sram_addr/sram_wdata driven from latched registers and held stable every ACCESS cycle.
REQ-023 ACCESS SHALL last exactly WAIT_CYCLES cycles; on the last cycle sram_rdata SHALL be captured into the response register (reads), or the register set to 0 (writes), then state moves to DONE.
REQ-024 DONE: resp_valid[grant]=1 for exactly one cycle with resp_rdata valid; sram_en=0, sram_we=0; next state IDLE.
REQ-025 Latency: request accepted at cycle T SHALL produce resp_valid at T+WAIT_CYCLES+1; throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-026 Outside ACCESS, sram_en and sram_we SHALL be 0.
REQ-027 Requests arriving while busy SHALL be held off (req_ready=0) and never dropped or reordered within a channel.
REQ-028 Changes on req_* after acceptance SHALL NOT affect the in-flight transaction.
REQ-029 resp_rdata SHALL be held between responses and not sampled by requesters outside resp_valid.

Reset
REQ-030 On reset SHALL set state to IDLE; set req_ready, resp_valid, sram_en, sram_we and busy to 0; set sram_addr, sram_wdata and resp_rdata to 0; set last_grant to NUM_CH-1 so that channel 0 wins first.
REQ-031 Reset asserted mid-ACCESS or DONE SHALL abort the transaction: sram_en=0 from the next edge and no resp_valid is issued for it.

Verification
REQ-032 Single read, NUM_CH=2, WAIT_CYCLES=1: ch0 reads 0x100 with sram_rdata=0xDEADBEEF -> req_ready[0] in cycle T, sram_en with addr 0x100 in T+1, resp_valid[0] with rdata 0xDEADBEEF in T+2.
REQ-033 Write, WAIT_CYCLES=3: ch1 writes we=0x3, addr 0x20, wdata 0x1234 -> sram_en high 3 cycles with stable addr/we/wdata, resp_valid[1] at T+4, resp_rdata=0.
REQ-034 Round-robin contention, RR_MODE=1: ch0 and ch1 held valid continuously -> grants ch0, ch1, ch0, ch1 starting from reset; fixed mode (RR_MODE=0) -> grants ch0 on every transaction.
REQ-035 NUM_CH=4 round-robin wrap: last_grant=3 with ch0 and ch2 valid -> ch0 granted; next grant -> ch2.
REQ-036 Reset on the 2nd ACCESS cycle of a WAIT_CYCLES=3 read -> sram_en=0 and busy=0 after the reset edge, no resp_valid, and the next request is granted normally to ch0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Multi-channel SRAM arbiter: fixed-priority or round-robin grant,
// fixed-latency single-port SRAM access, one-cycle response pulse.
module mem_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int RR_MODE     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CH-1:0]      req_valid,
    output logic [NUM_CH-1:0]      req_ready,
    input  logic [NUM_CH*DW/8-1:0] req_we,
    input  logic [NUM_CH*AW-1:0]   req_addr,
    input  logic [NUM_CH*DW-1:0]   req_wdata,
    output logic [NUM_CH-1:0]      resp_valid,
    output logic [DW-1:0]          resp_rdata,
    output logic                   sram_en,
    output logic [DW/8-1:0]        sram_we,
    output logic [AW-1:0]          sram_addr,
    output logic [DW-1:0]          sram_wdata,
    input  logic [DW-1:0]          sram_rdata,
    output logic                   busy
);

    localparam int BW = DW / 8;
    localparam int CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] last_grant;
    logic [CW-1:0] grant_q;
    logic [CW-1:0] grant_idx;
    logic          grant_found;
    logic [3:0]    wait_cnt;

    // Search order starts just past the previous winner in round-robin mode.
    always_comb begin
        int c;
        c           = 0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_MODE != 0) begin
                c = (int'(last_grant) + 1 + k) % NUM_CH;
            end else begin
                c = k;
            end
            if (!grant_found && req_valid[c]) begin
                grant_found = 1'b1;
                grant_idx   = CW'(c);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    // sram_we doubles as the latched byte-enable of the in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= CW'(NUM_CH - 1);
            grant_q    <= '0;
            wait_cnt   <= '0;
            sram_en    <= 1'b0;
            sram_we    <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_found) begin
                        grant_q    <= grant_idx;
                        last_grant <= grant_idx;
                        sram_en    <= 1'b1;
                        sram_we    <= req_we[grant_idx*BW +: BW];
                        sram_addr  <= req_addr[grant_idx*AW +: AW];
                        sram_wdata <= req_wdata[grant_idx*DW +: DW];
                        wait_cnt   <= 4'(WAIT_CYCLES - 1);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        sram_en    <= 1'b0;
                        sram_we    <= '0;
                        resp_rdata <= (sram_we == '0) ? sram_rdata : '0;
                        resp_valid <= NUM_CH'(1) << grant_q;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    resp_valid <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: 4-channel round-robin
// instance against a reference model, plus a 2-channel fixed-priority one.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int W  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*BW-1:0]   req_we = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              sram_en;
    logic [BW-1:0]     sram_we;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic [DW-1:0]     sram_rdata;
    logic              busy;

    logic [1:0]        req_valid2 = '0;
    logic [1:0]        req_ready2;
    logic [2*BW-1:0]   req_we2 = '0;
    logic [2*AW-1:0]   req_addr2 = '0;
    logic [2*DW-1:0]   req_wdata2 = '0;
    logic [1:0]        resp_valid2;
    logic [DW-1:0]     resp_rdata2;
    logic              sram_en2;
    logic [BW-1:0]     sram_we2;
    logic [AW-1:0]     sram_addr2;
    logic [DW-1:0]     sram_wdata2;
    logic              busy2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(
        .NUM_CH(N), .AW(AW), .DW(DW), .WAIT_CYCLES(W), .RR_MODE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    mem_arbiter #(
        .NUM_CH(2), .AW(AW), .DW(DW), .WAIT_CYCLES(1), .RR_MODE(0)
    ) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
        .sram_en(sram_en2), .sram_we(sram_we2), .sram_addr(sram_addr2),
        .sram_wdata(sram_wdata2), .sram_rdata(32'hDEADBEEF), .busy(busy2)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | (i * 32'h1111);
    endfunction

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (sram_en) begin
            for (int b = 0; b < BW; b++)
                if (sram_we[b]) mem[sram_addr[5:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
    end
    assign sram_rdata = mem[sram_addr[5:2]];

    typedef struct {
        int          ch;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    int          last_g = N - 1;
    int          next_free = 0;
    int          acc_start = -100;
    bit          model_ok = 1'b0;
    logic [3:0]  cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    // Reference: serial transactions, W+2 cycles each, rotating priority.
    always @(negedge clk) begin
        logic         exp_busy;
        logic         exp_en;
        logic [N-1:0] exp_ready;
        int           pick;
        int           c;
        exp_t         e;
        if (model_ok) begin
            exp_busy = (cyc < next_free);
            chk("busy", busy, exp_busy);
            exp_en = (cyc >= acc_start) && (cyc < acc_start + W);
            chk("sram_en", sram_en, exp_en);
            if (exp_en) begin
                chk("sram_addr", sram_addr, cur_addr);
                chk("sram_we", sram_we, cur_we);
                chk("sram_wdata", sram_wdata, cur_wdata);
            end else begin
                chk("sram_we_idle", sram_we, 0);
            end
            exp_ready = '0;
            pick = -1;
            if (!reset && !exp_busy) begin
                for (int k = 1; k <= N; k++) begin
                    c = (last_g + k) % N;
                    if (pick < 0 && req_valid[c]) pick = c;
                end
            end
            if (pick >= 0) exp_ready[pick] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            if (pick >= 0) begin
                last_g    = pick;
                next_free = cyc + W + 2;
                acc_start = cyc + 1;
                cur_we    = req_we[pick*BW +: BW];
                cur_addr  = req_addr[pick*AW +: AW];
                cur_wdata = req_wdata[pick*DW +: DW];
                e.ch  = pick;
                e.due = cyc + W + 1;
                if (cur_we == 4'h0) begin
                    e.data = ref_mem[cur_addr[5:2]];
                end else begin
                    for (int b = 0; b < BW; b++)
                        if (cur_we[b]) ref_mem[cur_addr[5:2]][b*8 +: 8] = cur_wdata[b*8 +: 8];
                    e.data = '0;
                end
                sbq.push_back(e);
            end
        end
        if (reset) begin
            model_ok  = 1'b1;
            last_g    = N - 1;
            next_free = cyc + 1;
            acc_start = -100;
            for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (model_ok) begin
            if (resp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("resp_unexpected", resp_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_ch", resp_valid, 64'(1) << e.ch);
                    chk("resp_rdata", resp_rdata, e.data);
                    chk("resp_latency", cyc, e.due);
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk("resp_missing", resp_valid, 64'(1) << e.ch);
            end
            if (reset) sbq.delete();
        end
    end

    task automatic new_req(input int i);
        req_valid[i] = 1'b1;
        if ($urandom % 2 == 0) req_we[i*BW +: BW] = 4'($urandom_range(1, 15));
        else req_we[i*BW +: BW] = 4'h0;
        req_addr[i*AW +: AW] = {26'h0, 4'($urandom % 16), 2'b00};
        req_wdata[i*DW +: DW] = $urandom;
    endtask

    task automatic cycle_hs(output logic [N-1:0] hs);
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int n, input bit gen);
        logic [N-1:0] hs;
        for (int t = 0; t < n; t++) begin
            cycle_hs(hs);
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    req_valid[i] = 1'b0;
                    req_addr[i*AW +: AW] = $urandom;
                    req_we[i*BW +: BW] = 4'($urandom);
                    req_wdata[i*DW +: DW] = $urandom;
                end
                if (gen && !req_valid[i] && $urandom % 3 == 0) new_req(i);
            end
        end
    endtask

    initial begin
        logic [N-1:0] hs;
        int           g[4];
        int           n;
        bit           got;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_busy2", busy2, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_random(600, 1'b1);
        run_random(40, 1'b0);
        chk("drain_valid", req_valid, 0);
        chk("drain_queue", sbq.size(), 0);

        req_valid = 4'b0100;
        req_we[2*BW +: BW] = 4'h0;
        req_addr[2*AW +: AW] = 32'h14;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle_hs(hs);
            if (hs[2]) got = 1'b1;
        end
        chk("abort_accept", got, 1);
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_sram_en", sram_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_resp", resp_valid, 0);
        @(posedge clk);
        #1;

        new_req(0);
        new_req(2);
        n = 0;
        for (int k = 0; k < 30 && n < 2; k++) begin
            cycle_hs(hs);
            for (int i = 0; i < N; i++)
                if (hs[i]) begin
                    g[n] = i;
                    n++;
                    req_valid[i] = 1'b0;
                end
        end
        chk("wrap_count", n, 2);
        chk("wrap_first", g[0], 0);
        chk("wrap_second", g[1], 2);

        new_req(0);
        new_req(1);
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            cycle_hs(hs);
            for (int i = 0; i < N; i++)
                if (hs[i]) begin
                    g[n] = i;
                    n++;
                    new_req(i);
                end
        end
        req_valid = '0;
        chk("rr_count", n, 4);
        chk("rr_g0", g[0], 0);
        chk("rr_g1", g[1], 1);
        chk("rr_g2", g[2], 0);
        chk("rr_g3", g[3], 1);
        run_random(20, 1'b0);
        chk("final_queue", sbq.size(), 0);

        req_valid2 = 2'b01;
        req_we2[0 +: BW] = 4'h0;
        req_addr2[0 +: AW] = 32'h100;
        @(negedge clk);
        chk("d2_ready", req_ready2, 2'b01);
        @(posedge clk);
        #1;
        req_valid2 = 2'b00;
        req_addr2[0 +: AW] = 32'h0;
        @(negedge clk);
        chk("d2_sram_en", sram_en2, 1);
        chk("d2_sram_addr", sram_addr2, 32'h100);
        chk("d2_busy", busy2, 1);
        chk("d2_hold_ready", req_ready2, 0);
        @(negedge clk);
        chk("d2_resp_valid", resp_valid2, 2'b01);
        chk("d2_resp_rdata", resp_rdata2, 32'hDEADBEEF);
        chk("d2_sram_off", sram_en2, 0);
        @(posedge clk);
        #1;

        req_valid2 = 2'b11;
        req_we2[BW +: BW] = 4'h3;
        req_addr2[AW +: AW] = 32'h20;
        req_wdata2[DW +: DW] = 32'h1234;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_ready2 != 2'b00) begin
                n++;
                chk("d2_fixed_grant", req_ready2, 2'b01);
            end
            @(posedge clk);
            #1;
        end
        chk("d2_fixed_count", n, 4);
        req_valid2 = 2'b10;
        @(negedge clk);
        chk("d2_ch1_ready", req_ready2, 2'b10);
        @(posedge clk);
        #1;
        req_valid2 = 2'b00;
        @(negedge clk);
        chk("d2_write_we", sram_we2, 4'h3);
        @(negedge clk);
        chk("d2_write_resp", resp_valid2, 2'b10);
        chk("d2_write_rdata", resp_rdata2, 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
